// File: rtl/maxpool_pkg.sv
// maxpool_pkg: shared dimensions, FSM state type and window addressing for maxpool1_2x2_pool
//   IN_DIM/OUT_DIM  side length of input (28) and pooled (14) maps
//   CHANNELS        number of feature maps (2)
//   IN_SIZE/OUT_SIZE elements per input (784) and pooled (196) map
//   state_t         IDLE / RUN / DONE
package maxpool_pkg;
    localparam int IN_DIM   = 28;
    localparam int OUT_DIM  = 14;
    localparam int CHANNELS = 2;
    localparam int IN_SIZE  = IN_DIM * IN_DIM;
    localparam int OUT_SIZE = OUT_DIM * OUT_DIM;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Flat input index of the top-left element of the 2x2 window behind pooled element i.
    function automatic int win_base(input int i);
        return (i / OUT_SIZE) * IN_SIZE + 2 * ((i % OUT_SIZE) / OUT_DIM) * IN_DIM + 2 * (i % OUT_DIM);
    endfunction
endpackage

// File: rtl/maxpool1_2x2_pool_max4.sv
// max4: combinational two's-complement maximum of four bitwidth-wide values
//   a, b, c, d  in   candidate values (signed)
//   y           out  largest of the four
module max4 #(
    parameter int bitwidth = 32
) (
    input  logic [bitwidth-1:0] a,
    input  logic [bitwidth-1:0] b,
    input  logic [bitwidth-1:0] c,
    input  logic [bitwidth-1:0] d,
    output logic [bitwidth-1:0] y
);
    logic [bitwidth-1:0] ab, cd;

    always_comb begin
        ab = $signed(a) > $signed(b) ? a : b;
        cd = $signed(c) > $signed(d) ? c : d;
        y  = $signed(ab) > $signed(cd) ? ab : cd;
    end
endmodule

// File: rtl/maxpool1_2x2_pool.sv
// maxpool1_2x2_pool: 2x2 stride-2 max pooling of two 28x28 maps to two 14x14 maps
//   clk                       in   rising-edge clock
//   reset                     in   asynchronous active-high reset
//   featuremap1               in   input maps, element (c,r,col) at c*784+r*28+col
//   enable                    in   start request, sampled in IDLE
//   reply_from_next_device    in   consumer acknowledge, sampled in DONE
//   featuremap1_maxpooled     out  pooled maps, element (c,r,col) at c*196+r*14+col
//   finished_for_next_device  out  result valid, held until acknowledged
//   reply_to_last_device      out  one-cycle pulse once the input has been consumed
// Build option: define MAXPOOL1_DUAL_CH_EN to pool both channels in parallel
// (196 steps per run instead of 392).
module maxpool1_2x2_pool
    import maxpool_pkg::*;
#(
    parameter int bitwidth = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [CHANNELS*IN_SIZE*bitwidth-1:0]   featuremap1,
    input  logic                                   enable,
    input  logic                                   reply_from_next_device,
    output logic [CHANNELS*OUT_SIZE*bitwidth-1:0]  featuremap1_maxpooled,
    output logic                                   finished_for_next_device,
    output logic                                   reply_to_last_device
);
`ifdef MAXPOOL1_DUAL_CH_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif
    localparam int STEPS = CHANNELS * OUT_SIZE / LANES;

    state_t              state, state_n;
    logic [8:0]          counter;
    logic                last;
    int                  out_idx [LANES];
    int                  base    [LANES];
    logic [bitwidth-1:0] pooled  [LANES];

    assign last = counter == 9'(STEPS - 1);
    assign finished_for_next_device = state == DONE;

    // Lane l handles output element counter + l*196, i.e. lane 1 covers channel 1.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign out_idx[l] = int'(counter) + l * OUT_SIZE;
        assign base[l]    = win_base(out_idx[l]);
        max4 #(.bitwidth(bitwidth)) u_max4 (
            .a(featuremap1[base[l]*bitwidth +: bitwidth]),
            .b(featuremap1[(base[l]+1)*bitwidth +: bitwidth]),
            .c(featuremap1[(base[l]+IN_DIM)*bitwidth +: bitwidth]),
            .d(featuremap1[(base[l]+IN_DIM+1)*bitwidth +: bitwidth]),
            .y(pooled[l])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = enable ? RUN : IDLE;
            RUN:     state_n = last ? DONE : RUN;
            DONE:    state_n = reply_from_next_device ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter               <= '0;
            reply_to_last_device  <= 1'b0;
            featuremap1_maxpooled <= '0;
        end else begin
            counter              <= state == RUN && !last ? counter + 9'd1 : '0;
            reply_to_last_device <= state == RUN && last;
            if (state == RUN)
                for (int l = 0; l < LANES; l++)
                    featuremap1_maxpooled[out_idx[l]*bitwidth +: bitwidth] <= pooled[l];
        end
    end
endmodule

// File: tb/tb_maxpool1_2x2_pool.sv
// tb_maxpool1_2x2_pool: directed self-checking bench for maxpool1_2x2_pool
module tb_maxpool1_2x2_pool;
    import maxpool_pkg::*;

    localparam int W    = 32;
    localparam int NOUT = CHANNELS * OUT_SIZE;
`ifdef MAXPOOL1_DUAL_CH_EN
    localparam int LAT = 197;
`else
    localparam int LAT = 393;
`endif

    logic                          clk = 1'b0;
    logic                          reset;
    logic [CHANNELS*IN_SIZE*W-1:0] featuremap1;
    logic                          enable;
    logic                          reply_from_next_device;
    logic [NOUT*W-1:0]             featuremap1_maxpooled;
    logic                          finished_for_next_device;
    logic                          reply_to_last_device;
    logic [NOUT*W-1:0]             exp_out;
    int                            checks = 0;
    int                            errors = 0;

    always #5 clk = ~clk;

    maxpool1_2x2_pool #(.bitwidth(W)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .featuremap1              (featuremap1),
        .enable                   (enable),
        .reply_from_next_device   (reply_from_next_device),
        .featuremap1_maxpooled    (featuremap1_maxpooled),
        .finished_for_next_device (finished_for_next_device),
        .reply_to_last_device     (reply_to_last_device)
    );

    function automatic int first_diff();
        for (int i = 0; i < NOUT; i++)
            if (featuremap1_maxpooled[i*W +: W] !== exp_out[i*W +: W]) return i;
        return -1;
    endfunction

    function automatic logic [W-1:0] got(input int i);
        return featuremap1_maxpooled[i*W +: W];
    endfunction

    function automatic logic [W-1:0] want(input int i);
        return exp_out[i*W +: W];
    endfunction

    task automatic clear_all();
        featuremap1 = '0;
        exp_out     = '0;
    endtask

    task automatic set_in(input int idx, input int v);
        featuremap1[idx*W +: W] = v;
    endtask

    task automatic set_exp(input int idx, input int v);
        exp_out[idx*W +: W] = v;
    endtask

    // Starts a run (or continues one with enable already held) and counts edges,
    // the enable-sampling edge being edge 1, until finished is seen.
    task automatic do_run(input bit hold, output int edges, output int early);
        @(negedge clk);
        enable = 1'b1;
        edges  = -1;
        early  = 0;
        for (int n = 1; n <= LAT + 50; n++) begin
            @(posedge clk);
            #1;
            if (!hold) enable = 1'b0;
            if (finished_for_next_device) begin
                edges = n;
                break;
            end
            if (reply_to_last_device) early++;
        end
    endtask

    task automatic ack(output logic fin);
        @(negedge clk);
        reply_from_next_device = 1'b1;
        @(posedge clk);
        #1;
        fin = finished_for_next_device;
        reply_from_next_device = 1'b0;
    endtask

    task automatic load_basic();
        clear_all();
        set_in(0, 1); set_in(1, 2); set_in(28, 3); set_in(29, 7);
        set_exp(0, 7);
    endtask

    task automatic load_signed();
        clear_all();
        set_in(0, -5); set_in(1, -2); set_in(28, -9); set_in(29, -1);
        set_exp(0, -1);
        set_in(2, 32'h80000000); set_in(3, 32'h80000000); set_in(30, 32'h80000001); set_in(31, 32'h80000000);
        set_exp(1, 32'h80000001);
        set_in(56, 32'h7FFFFFFF); set_in(57, 32'h80000000); set_in(84, 0); set_in(85, -1);
        set_exp(14, 32'h7FFFFFFF);
        set_in(58, 5); set_in(59, 5); set_in(86, -100); set_in(87, 5);
        set_exp(15, 5);
        set_in(784, -3); set_in(785, -3); set_in(812, -3); set_in(813, -3);
        set_exp(196, -3);
    endtask

    task automatic load_index();
        clear_all();
        set_in(1567, 9);
        set_exp(391, 9);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        reply_from_next_device = 1'b0;
        featuremap1 = '0;
        #55;
        checks++;
        if (featuremap1_maxpooled !== '0) begin
            errors++;
            $display("FAIL reset_bus first nonzero elem %0d got %h", first_diff(), got(first_diff()));
        end
        checks++;
        if (finished_for_next_device !== 1'b0) begin
            errors++;
            $display("FAIL reset_finished got %b exp 0", finished_for_next_device);
        end
        checks++;
        if (reply_to_last_device !== 1'b0) begin
            errors++;
            $display("FAIL reset_reply got %b exp 0", reply_to_last_device);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int edges, early, d, bad;
        logic fin;
        load_basic();
        do_run(1'b0, edges, early);
        checks++;
        if (edges !== LAT) begin
            errors++;
            $display("FAIL basic_latency got %0d exp %0d", edges, LAT);
        end
        checks++;
        if (reply_to_last_device !== 1'b1 || early !== 0) begin
            errors++;
            $display("FAIL basic_reply_pulse got %b (early %0d) exp 1 (early 0)", reply_to_last_device, early);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL basic_bus elem %0d got %h exp %h", d, got(d), want(d));
        end
        checks++;
        if (got(0) !== 32'd7) begin
            errors++;
            $display("FAIL basic_out0 got %h exp 00000007", got(0));
        end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (finished_for_next_device !== 1'b1 || reply_to_last_device !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_hold got %0d bad cycles exp 0", bad);
        end
        ack(fin);
        checks++;
        if (fin !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack got finished %b exp 0", fin);
        end
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (finished_for_next_device !== 1'b0 || featuremap1_maxpooled !== exp_out) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_idle got %0d bad cycles exp 0", bad);
        end
    endtask

    task automatic test_signed();
        int edges, early, d;
        logic fin;
        load_signed();
        do_run(1'b0, edges, early);
        checks++;
        if (edges !== LAT) begin
            errors++;
            $display("FAIL signed_latency got %0d exp %0d", edges, LAT);
        end
        checks++;
        if (got(0) !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL signed_out0 got %h exp ffffffff", got(0));
        end
        checks++;
        if (got(14) !== 32'h7FFFFFFF) begin
            errors++;
            $display("FAIL signed_out14 got %h exp 7fffffff", got(14));
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL signed_bus elem %0d got %h exp %h", d, got(d), want(d));
        end
        ack(fin);
    endtask

    task automatic test_index();
        int edges, early, d;
        logic fin;
        load_index();
        do_run(1'b0, edges, early);
        checks++;
        if (got(391) !== 32'd9) begin
            errors++;
            $display("FAIL index_out391 got %h exp 00000009", got(391));
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL index_bus elem %0d got %h exp %h", d, got(d), want(d));
        end
        ack(fin);
    endtask

    task automatic test_back_to_back();
        int edges, early, d;
        logic fin;
        load_signed();
        do_run(1'b1, edges, early);
        load_index();
        ack(fin);
        checks++;
        if (fin !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ack got finished %b exp 0", fin);
        end
        do_run(1'b1, edges, early);
        enable = 1'b0;
        checks++;
        if (edges !== LAT) begin
            errors++;
            $display("FAIL b2b_latency got %0d exp %0d", edges, LAT);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL b2b_bus elem %0d got %h exp %h", d, got(d), want(d));
        end
        ack(fin);
    endtask

    task automatic test_reset_midrun();
        int edges, early, d;
        logic fin;
        load_basic();
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (99) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (featuremap1_maxpooled !== '0 || finished_for_next_device !== 1'b0 || reply_to_last_device !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset got out0 %h finished %b reply %b exp all 0",
                     got(0), finished_for_next_device, reply_to_last_device);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        do_run(1'b0, edges, early);
        checks++;
        if (edges !== LAT) begin
            errors++;
            $display("FAIL midrun_latency got %0d exp %0d", edges, LAT);
        end
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL midrun_bus elem %0d got %h exp %h", d, got(d), want(d));
        end
        ack(fin);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_index();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
